// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite master: turns single-cycle write/read requests into one AXI transaction
// at a time, with a per-phase watchdog that aborts a stalled transaction with SLVERR.
module axi_lite_master_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  busy,
    output logic                  wr_done,
    output logic                  rd_done,
    output logic [1:0]            resp,
    output logic                  timeout,
    output logic [DATA_W-1:0]     rd_data,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, hs_any;
    logic             aw_ok, w_ok, expire;

    assign aw_hs  = m_axi_awvalid & m_axi_awready;
    assign w_hs   = m_axi_wvalid  & m_axi_wready;
    assign b_hs   = m_axi_bvalid  & m_axi_bready;
    assign ar_hs  = m_axi_arvalid & m_axi_arready;
    assign r_hs   = m_axi_rvalid  & m_axi_rready;
    assign hs_any = aw_hs | w_hs | b_hs | ar_hs | r_hs;

    // In WR a dropped valid means that channel already handshook.
    assign aw_ok  = !m_axi_awvalid || aw_hs;
    assign w_ok   = !m_axi_wvalid  || w_hs;
    assign expire = (cnt == CNT_W'(TIMEOUT - 1));
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_done       <= 1'b0;
            rd_done       <= 1'b0;
            timeout       <= 1'b0;
            resp          <= 2'b00;
            rd_data       <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            timeout <= 1'b0;
            if (state != IDLE && !hs_any && expire) begin
                // Watchdog abort: withdraw everything and report SLVERR.
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
                timeout       <= 1'b1;
                resp          <= 2'b10;
                if (state == WR || state == WR_RESP) wr_done <= 1'b1;
                else                                 rd_done <= 1'b1;
                cnt   <= '0;
                state <= IDLE;
            end else begin
                if (hs_any)             cnt <= '0;
                else if (state != IDLE) cnt <= cnt + 1'b1;
                case (state)
                    IDLE: begin
                        if (wr_en) begin
                            m_axi_awaddr  <= wr_addr;
                            m_axi_wdata   <= wr_data;
                            m_axi_wstrb   <= wr_strb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR;
                        end else if (rd_en) begin
                            m_axi_araddr  <= rd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                    WR: begin
                        if (aw_hs) m_axi_awvalid <= 1'b0;
                        if (w_hs)  m_axi_wvalid  <= 1'b0;
                        if (aw_ok && w_ok) begin
                            m_axi_bready <= 1'b1;
                            state        <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (b_hs) begin
                            m_axi_bready <= 1'b0;
                            resp         <= m_axi_bresp;
                            wr_done      <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    RD_ADDR: begin
                        if (ar_hs) begin
                            m_axi_arvalid <= 1'b0;
                            m_axi_rready  <= 1'b1;
                            state         <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (r_hs) begin
                            m_axi_rready <= 1'b0;
                            rd_data      <= m_axi_rdata;
                            resp         <= m_axi_rresp;
                            rd_done      <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Randomized scoreboard bench for axi_lite_master_ctrl against a memory-backed AXI slave
// and a per-transaction reference model.
module tb_axi_lite_master_ctrl;
    localparam int AW = 7, DW = 32, SW = 4, TMO = 8, NEVER = 1000;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en = 0, rd_en = 0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [SW-1:0] wr_strb = '0;
    logic          busy, wr_done, rd_done, timeout;
    logic [1:0]    resp;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0;
    logic          m_axi_arready = 0, m_axi_rvalid = 0;
    logic [1:0]    m_axi_bresp = 0, m_axi_rresp = 0;
    logic [DW-1:0] m_axi_rdata = '0;

    axi_lite_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .busy(busy), .wr_done(wr_done), .rd_done(rd_done), .resp(resp),
        .timeout(timeout), .rd_data(rd_data),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_wr;
        logic [1:0]  resp;
        bit          tmo;
        logic [31:0] rdata;
        int          exp_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave: memory with programmable per-channel waits ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 0, rresp_cfg = 0;
    logic [31:0] smem [0:127];
    logic [31:0] rmem [0:127];
    logic [31:0] last_rd = '0;

    initial begin
        int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
        bit have_aw = 0, have_w = 0;
        logic [AW-1:0] cap_a = '0, cap_ar = '0;
        logic [31:0]   cap_d = '0;
        logic [3:0]    cap_s = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !busy) begin
                {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                have_aw = 0; have_w = 0;
            end else begin
                if (m_axi_awvalid) begin
                    m_axi_awready = (aw_c >= aw_dly); aw_c++;
                    if (m_axi_awready) begin have_aw = 1; cap_a = m_axi_awaddr; end
                end else begin m_axi_awready = 0; aw_c = 0; end
                if (m_axi_wvalid) begin
                    m_axi_wready = (w_c >= w_dly); w_c++;
                    if (m_axi_wready) begin have_w = 1; cap_d = m_axi_wdata; cap_s = m_axi_wstrb; end
                end else begin m_axi_wready = 0; w_c = 0; end
                if (have_aw && have_w) begin
                    for (int b = 0; b < 4; b++)
                        if (cap_s[b]) smem[cap_a][8*b +: 8] = cap_d[8*b +: 8];
                    have_aw = 0; have_w = 0;
                end
                if (m_axi_bready) begin
                    m_axi_bvalid = (b_c >= b_dly); m_axi_bresp = bresp_cfg; b_c++;
                end else begin m_axi_bvalid = 0; b_c = 0; end
                if (m_axi_arvalid) begin
                    m_axi_arready = (ar_c >= ar_dly); ar_c++;
                    if (m_axi_arready) cap_ar = m_axi_araddr;
                end else begin m_axi_arready = 0; ar_c = 0; end
                if (m_axi_rready) begin
                    m_axi_rvalid = (r_c >= r_dly); m_axi_rdata = smem[cap_ar];
                    m_axi_rresp = rresp_cfg; r_c++;
                end else begin m_axi_rvalid = 0; r_c = 0; end
            end
        end
    end

    // ---------------- monitor ----------------
    logic          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [AW-1:0] p_awa = '0, p_ara = '0;
    logic [DW-1:0] p_wd = '0;
    logic [SW-1:0] p_ws = '0;
    exp_t          e;

    initial forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
            {p_awv, p_wv, p_arv} = '0;
        end else begin
            if (wr_done || rd_done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: wr_done=%0b rd_done=%0b, required none (cycle %0d)",
                             wr_done, rd_done, cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_kind", {wr_done, rd_done}, e.is_wr ? 2'b10 : 2'b01);
                    check("resp", resp, e.resp);
                    check("timeout", timeout, e.tmo);
                    check("rd_data", rd_data, e.rdata);
                    if (e.exp_cyc >= 0) check("done_cycle", cyc, e.exp_cyc);
                end
            end else if (timeout) begin
                total++; bad++;
                $display("FAIL lone_timeout: timeout=1 without done, required 0 (cycle %0d)", cyc);
            end
            if (p_awv && !p_awr && !timeout) check("aw_stable", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awa});
            if (p_wv && !p_wr && !timeout)
                check("w_stable", {m_axi_wvalid, m_axi_wstrb, m_axi_wdata}, {1'b1, p_ws, p_wd});
            if (p_arv && !p_arr && !timeout) check("ar_stable", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_ara});
            if (!busy)
                check("idle_quiet", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
            p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awa = m_axi_awaddr;
            p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wd = m_axi_wdata; p_ws = m_axi_wstrb;
            p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_ara = m_axi_araddr;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_wait: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int da, input int dw, input int db, input logic [1:0] br,
                            input int lat, input bit with_rd);
        bit tmo;
        exp_t x;
        wait_idle();
        aw_dly = da; w_dly = dw; b_dly = db; bresp_cfg = br;
        tmo = (da >= TMO) || (dw >= TMO) || (db >= TMO);
        if (da < TMO && dw < TMO)
            for (int b = 0; b < 4; b++) if (s[b]) rmem[a][8*b +: 8] = d[8*b +: 8];
        x.is_wr = 1; x.resp = tmo ? 2'b10 : br; x.tmo = tmo; x.rdata = last_rd;
        x.exp_cyc = (lat < 0) ? -1 : cyc + lat;
        sb.push_back(x);
        wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1;
        rd_en = with_rd; rd_addr = 7'h04;
        @(negedge clk);
        wr_en = 0; rd_en = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int dar, input int dr, input logic [1:0] rr,
                           input int lat, input bit push);
        bit tmo;
        exp_t x;
        wait_idle();
        ar_dly = dar; r_dly = dr; rresp_cfg = rr;
        tmo = (dar >= TMO) || (dr >= TMO);
        if (push) begin
            if (!tmo) last_rd = rmem[a];
            x.is_wr = 0; x.resp = tmo ? 2'b10 : rr; x.tmo = tmo; x.rdata = last_rd;
            x.exp_cyc = (lat < 0) ? -1 : cyc + lat;
            sb.push_back(x);
        end
        rd_addr = a; rd_en = 1;
        @(negedge clk);
        rd_en = 0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            smem[i] = $urandom; rmem[i] = smem[i];
        end
        smem[4] = 32'hCAFE0001; rmem[4] = 32'hCAFE0001;

        repeat (2) @(negedge clk);
        check("rst_data", {rd_data, m_axi_wdata}, 0);
        check("rst_ctrl", {busy, wr_done, rd_done, resp, timeout, m_axi_awaddr, m_axi_awvalid, m_axi_wstrb,
                           m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready}, 0);
        rst_n = 1;
        @(negedge clk);

        do_write(7'h12, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 3, 0);
        do_write(7'h20, 32'h11223344, 4'b0101, 5, 1, 2, 2'b00, -1, 0);
        do_read(7'h04, 0, 2, 2'b00, -1, 1);

        // simultaneous request: write wins; then a rd_en pulse while busy
        do_write(7'h30, 32'hA5A5A5A5, 4'hF, 0, 0, 3, 2'b01, -1, 1);
        rd_en = 1; @(negedge clk); rd_en = 0;

        do_write(7'h12, 32'h55667788, 4'b1100, 0, 0, NEVER, 2'b00, 2 + TMO, 0);
        do_read(7'h12, 0, 0, 2'b00, 3, 1);
        do_read(7'h20, 1, 1, 2'b00, -1, 1);

        // reset in RD_DATA, then a write on the first cycle after release
        do_read(7'h04, 0, NEVER, 2'b00, -1, 0);
        @(negedge clk);
        check("rready_before_rst", m_axi_rready, 1);
        #2 rst_n = 0;
        #1;
        check("rst_mid_data", {rd_data, m_axi_wdata}, 0);
        check("rst_mid_ctrl", {busy, wr_done, rd_done, resp, timeout, m_axi_awaddr, m_axi_awvalid, m_axi_wstrb,
                               m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready}, 0);
        @(negedge clk);
        rst_n = 1;
        last_rd = '0;
        do_write(7'h40, 32'h0BADF00D, 4'hF, 0, 0, 0, 2'b00, 3, 0);
        do_read(7'h40, 0, 0, 2'b00, 3, 1);

        for (int it = 0; it < 120; it++) begin
            int a = $urandom_range(0, 15);
            int sel = $urandom_range(0, 7);
            int ch = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                int da = $urandom_range(0, 5), dw = $urandom_range(0, 5), db = $urandom_range(0, 5);
                if (sel == 0) begin
                    if (ch == 0) da = NEVER; else if (ch == 1) dw = NEVER; else db = NEVER;
                end
                do_write(7'(a), $urandom, 4'($urandom_range(0, 15)), da, dw, db,
                         2'($urandom_range(0, 3)), -1, 0);
            end else begin
                int dar = $urandom_range(0, 5), dr = $urandom_range(0, 5);
                if (sel == 0) begin
                    if (ch == 0) dar = NEVER; else dr = NEVER;
                end
                do_read(7'(a), dar, dr, 2'($urandom_range(0, 3)), -1, 1);
            end
        end

        wait_idle();
        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation still running, required finish");
        $fatal(1);
    end
endmodule

// File: doc/axi_lite_master_ctrl.md
AXI_LITE_MASTER_CTRL -- requirements
Module: axi_lite_master_ctrl

Interface
REQ-001 The block SHALL have a single clock `clk`, and reset `rst_n` SHALL be asynchronous and active-low.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- ADDR_W, 7, AXI address width.
- DATA_W, 32, data width; must be 32 or 64.
- TIMEOUT, 255, maximum cycles waited in any AXI phase; must be 1 or more.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- wr_en, in, 1, write request.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, DATA_W, write data.
- wr_strb, in, DATA_W/8, write byte strobes.
- rd_en, in, 1, read request.
- rd_addr, in, ADDR_W, read address.
- busy, out, 1, transaction in flight; new requests are ignored while high.
- wr_done, out, 1, one-cycle write-complete pulse.
- rd_done, out, 1, one-cycle read-complete pulse.
- resp, out, 2, BRESP/RRESP of the last transaction, valid on a done pulse.
- timeout, out, 1, one-cycle pulse accompanying the done pulse of an aborted transaction.
- rd_data, out, DATA_W, read data, held until the next read completes.
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master directions, with widths taken from ADDR_W and DATA_W.

Function
REQ-004 The FSM SHALL have the states IDLE, WR (AW/W phase), WR_RESP, RD_ADDR and RD_DATA, and busy SHALL be 1 in every state except IDLE.
REQ-005 Requests SHALL be accepted only in IDLE; when wr_en and rd_en are both 1 in the same cycle, the write SHALL win and the read SHALL be dropped, so the caller must re-assert it.
REQ-006 On accepting a write, the block SHALL register awaddr, wdata and wstrb and assert awvalid and wvalid on the next cycle, moving to WR.
REQ-007 In WR, awvalid SHALL drop the cycle after the AW handshake (awvalid and awready both 1), and wvalid SHALL drop the cycle after the W handshake; these are independent, so either order or simultaneous completion is legal.
REQ-008 Once both the AW and W handshakes have occurred, the block SHALL assert bready and move to WR_RESP.
REQ-009 In WR_RESP, on bvalid with bready, the block SHALL:
- drop bready;
- capture bresp into resp;
- pulse wr_done for 1 cycle;
- return to IDLE.
REQ-010 On accepting a read, the block SHALL register araddr, assert arvalid and move to RD_ADDR.
REQ-011 On the AR handshake, the block SHALL drop arvalid, assert rready and move to RD_DATA.
REQ-012 In RD_DATA, on rvalid with rready, the block SHALL:
- drop rready;
- capture rdata into rd_data and rresp into resp;
- pulse rd_done;
- return to IDLE.
REQ-013 Valid signals SHALL NOT be withdrawn before their handshake, and address, data and strobes SHALL be stable while the corresponding valid is 1.
REQ-014 A phase counter SHALL clear on every state entry and on every handshake, and increment each busy cycle.
REQ-015 When the phase counter reaches TIMEOUT, the block SHALL:
- drop all valids and readies;
- pulse the matching done signal together with timeout, with resp = 2'b10 (SLVERR);
- return to IDLE.
REQ-016 After a timeout, rd_data SHALL be left unchanged.
REQ-017 The minimum write latency SHALL be 3 cycles from wr_en to wr_done, with a zero-wait slave (ready tied high and bvalid the cycle after the handshake).
REQ-018 The minimum read latency SHALL be 3 cycles from rd_en to rd_done, with a zero-wait slave.
REQ-019 At most one AXI transaction SHALL be outstanding at any time.

Reset
REQ-020 Asserting rst_n low SHALL, asynchronously:
- force IDLE;
- clear all valid, ready and busy outputs, all done outputs and timeout;
- clear resp, rd_data, the phase counter and all AXI address/data/strobe outputs to 0.
REQ-021 A reset mid-transaction SHALL abandon the transaction without any done pulse, and the block SHALL accept a new request on the first cycle after reset is released.

Verification
REQ-022 Write 0x12 with data 0xDEADBEEF and strb 0xF to a zero-wait slave -> AW and W handshake in cycle 1, wr_done in cycle 3 with resp 00.
REQ-023 Slave asserts awready 4 cycles after wready -> wvalid drops first, awvalid is held stable until its handshake, and wr_done follows bvalid.
REQ-024 Read 0x04 from a slave returning 0xCAFE0001 with rresp 00 after 2 wait cycles -> rd_done with rd_data 0xCAFE0001 and resp 00.
REQ-025 wr_en and rd_en asserted in the same IDLE cycle -> only the write is issued; a rd_en pulse while busy is ignored.
REQ-026 With TIMEOUT=8, a slave that never asserts bvalid -> wr_done, timeout and resp 10 after 8 cycles in WR_RESP, followed by a normal read succeeding.
REQ-027 rst_n asserted low during RD_DATA -> all outputs 0 immediately and no rd_done; after release, a write completes normally.
